// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the RISC-V mul/div ALU: ALUctl opcodes, FSM encoding
// and opcode classification helpers.
package riscv_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;
    localparam logic [3:0] OP_REM   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // True for the four divide/remainder opcodes (they share the divide datapath).
    function automatic logic is_div_op(input logic [3:0] op);
        case (op)
            OP_DIVU, OP_REMU, OP_DIV, OP_REM: is_div_op = 1'b1;
            default:                          is_div_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it did not borrow.
module riscv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dvd_o
);

    logic [XLEN:0] trial_s;
    logic [XLEN:0] diff_s;

    assign trial_s = {rem_i, dvd_i[XLEN-1]};
    assign diff_s  = trial_s - {1'b0, divisor_i};

    // Restore on borrow; the quotient bit enters where the dividend bit left.
    always_comb begin
        rem_o = trial_s[XLEN-1:0];
        dvd_o = {dvd_i[XLEN-2:0], 1'b0};
        if (diff_s[XLEN] == 1'b0) begin
            rem_o = diff_s[XLEN-1:0];
            dvd_o = {dvd_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = trial_s[XLEN-1:0];
            dvd_o = {dvd_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/riscv_muldiv_alu.sv
// Multi-cycle RISC-V ALU: single-cycle logic/arith ops, shift-add multiply and
// restoring divide, with a start/busy/done handshake and registered result.
module riscv_muldiv_alu
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      ALUctl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] ALUOut,
    output logic            Zero,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ZERO_W  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                qneg_q, qneg_d, rneg_q, rneg_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                zero_q, busy_q, busy_d, done_q;

    logic [XLEN:0]       mul_sum_s;
    logic [XLEN-1:0]     step_rem_s, step_dvd_s, abs_a_s, abs_b_s;
    logic [2*XLEN-1:0]   iter_next_s;

    // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : ZERO_W)};
    assign abs_a_s   = A[XLEN-1] ? -A : A;
    assign abs_b_s   = B[XLEN-1] ? -B : B;

    riscv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .dvd_i     (acc_q[XLEN-1:0]),
        .divisor_i (opb_q),
        .rem_o     (step_rem_s),
        .dvd_o     (step_dvd_s)
    );

    assign iter_next_s = is_div_op(op_q) ? {step_rem_s, step_dvd_s}
                                         : {mul_sum_s, acc_q[XLEN-1:1]};

    // Next-state, operand capture and result selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = ALUctl;
                    busy_d  = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DONE;
                    acc_d   = {ZERO_W, A};
                    opb_d   = B;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    case (ALUctl)
                        OP_AND:  res_d = A & B;
                        OP_OR:   res_d = A | B;
                        OP_XOR:  res_d = A ^ B;
                        OP_NOR:  res_d = ~(A | B);
                        OP_ADD:  res_d = A + B;
                        OP_SUB:  res_d = A - B;
                        OP_SLT:  res_d = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
                        OP_SLTU: res_d = {{(XLEN-1){1'b0}}, (A < B)};
                        OP_MUL, OP_MULHU: state_d = S_RUN;
                        OP_DIVU, OP_REMU: begin
                            if (B == ZERO_W) begin
                                res_d = (ALUctl == OP_DIVU) ? ONES_W : A;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        OP_DIV, OP_REM: begin
                            if (B == ZERO_W) begin
                                res_d = (ALUctl == OP_DIV) ? ONES_W : A;
                            end else if ((A == MOST_NEG) && (B == ONES_W)) begin
                                res_d = (ALUctl == OP_DIV) ? A : ZERO_W;
                            end else begin
                                acc_d   = {ZERO_W, abs_a_s};
                                opb_d   = abs_b_s;
                                qneg_d  = A[XLEN-1] ^ B[XLEN-1];
                                rneg_d  = A[XLEN-1];
                                state_d = S_RUN;
                            end
                        end
                        default: res_d = ZERO_W;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = iter_next_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(XLEN)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    case (op_q)
                        OP_MUL:   res_d = iter_next_s[XLEN-1:0];
                        OP_MULHU: res_d = iter_next_s[2*XLEN-1:XLEN];
                        OP_DIVU:  res_d = iter_next_s[XLEN-1:0];
                        OP_REMU:  res_d = iter_next_s[2*XLEN-1:XLEN];
                        OP_DIV:   res_d = qneg_q ? -iter_next_s[XLEN-1:0] : iter_next_s[XLEN-1:0];
                        OP_REM:   res_d = rneg_q ? -iter_next_s[2*XLEN-1:XLEN] : iter_next_s[2*XLEN-1:XLEN];
                        default:  res_d = ZERO_W;
                    endcase
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= 4'b0000;
            acc_q   <= {(2*XLEN){1'b0}};
            opb_q   <= ZERO_W;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= ZERO_W;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
            zero_q  <= (res_d == ZERO_W);
            busy_q  <= busy_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    assign ALUOut = res_q;
    assign Zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/riscv_muldiv_alu.md
RISCV_MULDIV_ALU -- requirements
Module: riscv_muldiv_alu

Interface
REQ-001 Parameter XLEN, default 32; operand/result width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request; sampled only when busy=0.
REQ-005 ALUctl  input  4  operation select; sampled with start.
REQ-006 A  input  XLEN  operand A; sampled with start.
REQ-007 B  input  XLEN  operand B; sampled with start.
REQ-008 ALUOut  output  XLEN  registered result; held until the next accepted start completes.
REQ-009 Zero  output  1  registered; 1 when ALUOut == 0.
REQ-010 busy  output  1  1 from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse; ALUOut/Zero valid from this cycle.

Function
REQ-012 Single-cycle ops SHALL be: 0000 AND, 0001 OR, 0011 XOR, 0010 ADD (wrap mod 2^XLEN), 0110 SUB (wrap), 0111 SLT (signed, result 0/1), 1000 SLTU (unsigned, result 0/1), 1100 NOR.
REQ-013 Iterative ops SHALL be: 1001 MUL (low XLEN of product), 1010 MULHU (high XLEN of unsigned product), 1101 DIVU, 1110 REMU, 1011 DIV (signed, truncate toward zero), 1111 REM (signed, remainder takes sign of A).
REQ-014 Unlisted ALUctl codes SHALL produce ALUOut=0 with single-cycle latency.
REQ-015 States SHALL be IDLE, RUN, DONE; IDLE->DONE for single-cycle/special cases; IDLE->RUN for iterative ops; RUN->DONE when the iteration counter reaches XLEN; DONE->IDLE unconditionally.
REQ-016 Latency: start accepted in cycle 0 -> done in cycle 1 (single-cycle) or cycle XLEN+1 (iterative); busy=1 in cycles 1..XLEN for iterative ops and in cycle 1 for single-cycle ops; done=1 only in the DONE state.
REQ-017 Multiply SHALL be radix-2 shift-add over XLEN cycles using a 2*XLEN-bit accumulator.
REQ-018 Divide SHALL be restoring, one quotient bit per cycle over XLEN cycles, on operand magnitudes; signs restored in the final cycle.
REQ-019 Divide by zero SHALL complete in 1 cycle: DIVU/DIV -> all-ones, REMU/REM -> A.
REQ-020 Signed overflow (A = most-negative, B = -1) SHALL complete in 1 cycle: DIV -> A, REM -> 0.
REQ-021 start while busy=1 or in the DONE cycle SHALL be ignored with no effect on the operation in progress.
REQ-022 A, B and ALUctl SHALL be captured at acceptance; later changes SHALL not affect the result.
REQ-023 ALUOut and Zero SHALL change only in the cycle done rises (or on reset).

Reset
REQ-024 reset SHALL take priority over start and force: state IDLE, ALUOut=0, Zero=1, busy=0, done=0, counter=0.
REQ-025 reset asserted mid-operation SHALL abandon it; no done pulse for that operation.

Structure
REQ-026 Package riscv_alu_pkg SHALL hold the ALUctl opcode constants and the state encoding.
REQ-027 One sub-module, riscv_div_step (combinational restoring-divide step: remainder/quotient shift, trial subtract, select), SHALL be instantiated once.
REQ-028 Counter width SHALL be $clog2(XLEN)+1; no other parameters.

Verification (XLEN=32)
REQ-029 ADD A=5, B=7 -> done cycle 1, ALUOut=12, Zero=0; SUB A=9, B=9 -> ALUOut=0, Zero=1.
REQ-030 SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0.
REQ-031 MUL A=B=0xFFFFFFFF -> 0x00000001; MULHU -> 0xFFFFFFFE; done exactly at cycle 33; busy=1 cycles 1..32.
REQ-032 DIV A=-7, B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU -> 2; all at cycle 33.
REQ-033 DIVU A=10, B=0 -> 0xFFFFFFFF; REMU -> 10; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM -> 0; all done at cycle 1.
REQ-034 Start DIV, pulse start with new operands at cycle 5 -> ignored, original result at cycle 33; separate run with reset at cycle 10 -> next cycle busy=0, ALUOut=0, Zero=1, no done.
